// File: rtl/seq_stage_ctrl.sv
// Stage sequencer for the sequential Y86-64 core.
// Walks FETCH..PCUP one stage per cycle, owns the condition codes, the
// registered branch/cmov condition, the processor status and two counters.
module seq_stage_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic             instr_ok,
   input  logic             imem_error,
   input  logic [2:0]       cc_new,
   input  logic             mem_ack,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_req,
   output logic             wb_en,
   output logic             pc_en,
   output logic [2:0]       cc,
   output logic             cnd,
   output logic [1:0]       stat,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUP, S_HALT
   } state_t;

   state_t            r_state;
   logic [2:0]        r_cc;
   logic              r_cnd;
   logic [1:0]        r_stat;
   logic [CNT_W-1:0]  r_cycle_cnt;
   logic [CNT_W-1:0]  r_instr_cnt;
   logic [WAIT_W-1:0] r_wait;

   logic w_busy;
   logic w_is_cond;
   logic w_is_mem;
   logic w_bad_code;
   logic w_lt;
   logic w_cond;

   assign w_busy    = (r_state != S_IDLE) && (r_state != S_HALT);
   // cmovXX (2) and jXX (7) carry a condition selected by ifun
   assign w_is_cond = (icode == 4'h2) || (icode == 4'h7);
   // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
   assign w_is_mem  = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                      (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);
   assign w_bad_code = (icode > 4'hB) || (w_is_cond && (ifun > 4'h6));
   // signed less-than: SF ^ OF, with cc = {OF,SF,ZF}
   assign w_lt      = r_cc[1] ^ r_cc[2];

   // condition evaluation on the codes as they stand before this EXEC
   always_comb begin
      w_cond = 1'b0;
      case (ifun)
         4'h0:    w_cond = 1'b1;
         4'h1:    w_cond = w_lt | r_cc[0];
         4'h2:    w_cond = w_lt;
         4'h3:    w_cond = r_cc[0];
         4'h4:    w_cond = ~r_cc[0];
         4'h5:    w_cond = ~w_lt;
         4'h6:    w_cond = ~w_lt & ~r_cc[0];
         default: w_cond = 1'b0;
      endcase
   end

   // stage sequencing, status, flags and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cc        <= 3'b001;
         r_cnd       <= 1'b0;
         r_stat      <= STAT_AOK;
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
         r_wait      <= '0;
      end else begin
         if (w_busy) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (start) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_error) begin
                  r_state <= S_HALT;
                  r_stat  <= STAT_ADR;
               end else if (!instr_ok) begin
                  r_state <= S_HALT;
                  r_stat  <= STAT_INS;
               end else begin
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_bad_code) begin
                  r_state <= S_HALT;
                  r_stat  <= STAT_INS;
               end else if (icode == 4'h0) begin
                  // the halt instruction itself counts as retired
                  r_state     <= S_HALT;
                  r_stat      <= STAT_HLT;
                  r_instr_cnt <= r_instr_cnt + 1'b1;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (icode == 4'h6) r_cc <= cc_new;
               r_cnd   <= w_is_cond ? w_cond : 1'b0;
               r_wait  <= '0;
               r_state <= w_is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
               // an ack arriving on the expiry cycle still completes normally
               if (mem_ack) begin
                  if (dmem_error) begin
                     r_state <= S_HALT;
                     r_stat  <= STAT_ADR;
                  end else begin
                     r_state <= S_WB;
                  end
               end else if (r_wait == WAIT_LAST) begin
                  r_state <= S_HALT;
                  r_stat  <= STAT_ADR;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_WB: begin
               r_state <= S_PCUP;
            end
            S_PCUP: begin
               r_state     <= S_FETCH;
               r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign fetch_en  = (r_state == S_FETCH);
   assign decode_en = (r_state == S_DECODE);
   assign exec_en   = (r_state == S_EXEC);
   assign mem_req   = (r_state == S_MEM);
   assign wb_en     = (r_state == S_WB);
   assign pc_en     = (r_state == S_PCUP);
   assign busy      = w_busy;
   assign cc        = r_cc;
   assign cnd       = r_cnd;
   assign stat      = r_stat;
   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Bench for seq_stage_ctrl: directed cases plus random instruction streams,
// each instruction checked cycle by cycle against a per-instruction stage plan.
module tb_seq_stage_ctrl;

   localparam int CNT_W       = 32;
   localparam int MEM_TIMEOUT = 16;

   localparam logic [5:0] ST_F = 6'b100000;
   localparam logic [5:0] ST_D = 6'b010000;
   localparam logic [5:0] ST_E = 6'b001000;
   localparam logic [5:0] ST_M = 6'b000100;
   localparam logic [5:0] ST_W = 6'b000010;
   localparam logic [5:0] ST_P = 6'b000001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [3:0]       icode = 4'h1;
   logic [3:0]       ifun = 4'h0;
   logic             instr_ok = 1'b1;
   logic             imem_error = 1'b0;
   logic [2:0]       cc_new = 3'b000;
   logic             mem_ack = 1'b0;
   logic             dmem_error = 1'b0;
   logic             fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en;
   logic [2:0]       cc;
   logic             cnd;
   logic [1:0]       stat;
   logic             busy;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   logic [2:0]  m_cc;
   logic        m_cnd;
   logic [1:0]  m_stat;
   int unsigned m_cyc;
   int unsigned m_icnt;

   always #5 clk = ~clk;

   seq_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
      .instr_ok(instr_ok), .imem_error(imem_error), .cc_new(cc_new),
      .mem_ack(mem_ack), .dmem_error(dmem_error), .fetch_en(fetch_en),
      .decode_en(decode_en), .exec_en(exec_en), .mem_req(mem_req),
      .wb_en(wb_en), .pc_en(pc_en), .cc(cc), .cnd(cnd), .stat(stat),
      .busy(busy), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   wire [5:0] en_vec = {fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Y86 condition table, cc = {OF,SF,ZF}
   function automatic logic cond_f(input logic [3:0] fn, input logic [2:0] c);
      logic of_f, sf_f, zf_f;
      of_f = c[2]; sf_f = c[1]; zf_f = c[0];
      case (fn)
         4'd0: return 1'b1;
         4'd1: return (sf_f != of_f) || zf_f;
         4'd2: return (sf_f != of_f);
         4'd3: return zf_f;
         4'd4: return !zf_f;
         4'd5: return (sf_f == of_f);
         4'd6: return (sf_f == of_f) && !zf_f;
         default: return 1'b0;
      endcase
   endfunction

   // async reset asserted between edges; outputs must clear without a clock
   task automatic do_reset();
      mem_ack = 1'b0; start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_stages", {en_vec, busy}, 7'd0);
      chk("rst_cc", cc, 3'b001);
      chk("rst_cnd", cnd, 1'b0);
      chk("rst_stat", stat, 2'd0);
      chk("rst_counts", {cycle_cnt, instr_cnt}, 64'd0);
      #2 rst_n = 1'b1;
      m_cc = 3'b001; m_cnd = 1'b0; m_stat = 2'd0; m_cyc = 0; m_icnt = 0;
      step();
   endtask

   task automatic go();
      chk("idle_stages", {en_vec, busy}, 7'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("go_fetch", en_vec, ST_F);
   endtask

   // one instruction, starting with the DUT visible in FETCH
   task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input bit ok,
                            input bit ierr, input logic [2:0] ccn, input int ackw,
                            input bit derr);
      logic [5:0] plan[$];
      bit         halts = 0;
      bit         retire = 0;
      logic [1:0] hstat = 2'd0;
      int         j = 0;
      plan.push_back(ST_F);
      if (ierr) begin
         halts = 1; hstat = 2'd2;
      end else if (!ok) begin
         halts = 1; hstat = 2'd3;
      end else begin
         plan.push_back(ST_D);
         if (ic > 4'hB || ((ic == 4'h2 || ic == 4'h7) && fn > 4'h6)) begin
            halts = 1; hstat = 2'd3;
         end else if (ic == 4'h0) begin
            halts = 1; hstat = 2'd1; retire = 1;
         end else begin
            plan.push_back(ST_E);
            m_cnd = (ic == 4'h2 || ic == 4'h7) ? cond_f(fn, m_cc) : 1'b0;
            if (ic == 4'h6) m_cc = ccn;
            if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
               if (ackw < MEM_TIMEOUT) begin
                  for (int k = 0; k <= ackw; k++) plan.push_back(ST_M);
                  if (derr) begin
                     halts = 1; hstat = 2'd2;
                  end
               end else begin
                  for (int k = 0; k < MEM_TIMEOUT; k++) plan.push_back(ST_M);
                  halts = 1; hstat = 2'd2;
               end
            end
            if (!halts) begin
               plan.push_back(ST_W);
               plan.push_back(ST_P);
               retire = 1;
            end
         end
      end
      icode = ic; ifun = fn; instr_ok = ok; imem_error = ierr; cc_new = ccn;
      foreach (plan[k]) begin
         chk("stage", en_vec, plan[k]);
         if (plan[k] == ST_M) begin
            mem_ack    = (j == ackw);
            dmem_error = derr && (j == ackw);
            j++;
         end else begin
            mem_ack    = 1'b0;
            dmem_error = 1'($urandom);
         end
         start = 1'($urandom);
         step();
      end
      mem_ack = 1'b0; start = 1'b0;
      m_cyc += plan.size();
      if (retire) m_icnt++;
      if (halts) m_stat = hstat;
      chk("cc", cc, m_cc);
      chk("cnd", cnd, m_cnd);
      chk("stat", stat, m_stat);
      chk("instr_cnt", instr_cnt, m_icnt);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("after_stages", {en_vec, busy}, halts ? 7'd0 : {ST_F, 1'b1});
      $display("instr icode=%h ifun=%h ok=%0d ierr=%0d ackw=%0d derr=%0d cycles=%0d stat=%0d cc=%b cnd=%0d",
               ic, fn, ok, ierr, ackw, derr, plan.size(), stat, cc, cnd);
   endtask

   initial begin
      logic [3:0] ic, fn;
      #1;
      do_reset();
      go();

      // nop stream: 5-cycle loop, MEM skipped
      for (int i = 0; i < 3; i++) run_instr(4'h1, 4'h0, 1, 0, 3'b110, 0, 0);
      chk("nop_icnt", instr_cnt, 3);
      chk("nop_cycles", cycle_cnt, 15);

      // irmovq, subq giving ZF, then je / jne
      run_instr(4'h3, 4'h0, 1, 0, 3'b111, 0, 0);
      run_instr(4'h6, 4'h1, 1, 0, 3'b001, 0, 0);
      chk("subq_cc", cc, 3'b001);
      chk("subq_cnd", cnd, 1'b0);
      run_instr(4'h7, 4'h3, 1, 0, 3'b000, 0, 0);
      chk("je_cnd", cnd, 1'b1);
      run_instr(4'h7, 4'h4, 1, 0, 3'b000, 0, 0);
      chk("jne_cnd", cnd, 1'b0);

      // mrmovq with three wait cycles: 9 busy cycles
      begin
         int unsigned c0;
         c0 = cycle_cnt;
         run_instr(4'h5, 4'h0, 1, 0, 3'b000, 3, 0);
         chk("mrmov_cycles", cycle_cnt - c0, 9);
      end
      // ack on the expiry cycle completes the access
      run_instr(4'h5, 4'h0, 1, 0, 3'b000, MEM_TIMEOUT - 1, 0);

      // async reset in the middle of a memory access
      icode = 4'h5; ifun = 4'h0; mem_ack = 1'b0;
      step(); step(); step(); step();
      chk("midmem_req", {mem_req, busy}, 2'b11);
      do_reset();
      go();

      // memory timeout
      run_instr(4'h4, 4'h0, 1, 0, 3'b000, 100, 0);
      chk("timeout_stat", stat, 2'd2);
      start = 1'b1;
      step(); step();
      start = 1'b0;
      chk("halt_absorb", {en_vec, busy, stat}, {7'd0, 2'd2});
      do_reset(); go();

      run_instr(4'h0, 4'h0, 1, 0, 3'b000, 0, 0);
      chk("halt_stat", stat, 2'd1);
      chk("halt_icnt", instr_cnt, 1);
      do_reset(); go();
      run_instr(4'hC, 4'h0, 1, 0, 3'b000, 0, 0);
      chk("badcode_stat", stat, 2'd3);
      do_reset(); go();
      run_instr(4'h7, 4'h7, 1, 0, 3'b000, 0, 0);
      chk("badfun_stat", stat, 2'd3);
      do_reset(); go();
      run_instr(4'h8, 4'h0, 1, 0, 3'b000, 2, 1);
      do_reset(); go();
      run_instr(4'h1, 4'h0, 0, 1, 3'b000, 0, 0);
      do_reset(); go();
      run_instr(4'h1, 4'h0, 0, 0, 3'b000, 0, 0);
      do_reset(); go();

      // random instruction streams
      for (int n = 0; n < 300; n++) begin
         int ackw;
         bit ok, ierr, derr;
         ic = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(1, 11)) : 4'($urandom);
         fn = ($urandom_range(0, 7) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom);
         ok   = ($urandom_range(0, 31) != 0);
         ierr = ($urandom_range(0, 31) == 0);
         derr = ($urandom_range(0, 15) == 0);
         ackw = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 4));
         run_instr(ic, fn, ok, ierr, 3'($urandom), ackw, derr);
         if (m_stat != 2'd0) begin
            do_reset();
            go();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
